// File: rtl/decompressor_stream_parser.sv
// Splits an LZRW1 compressed byte stream into literal/copy items for decompressor_top.
// At most one byte is taken per cycle; each item is held on data_in until the decompressor takes it.
module decompressor_stream_parser #(
  parameter int CONTROL_BITS = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  byte_in,
  input  logic        byte_in_valid,
  input  logic        byte_in_last,
  output logic        byte_in_ready,
  output logic [15:0] data_in,
  output logic        control_word_in,
  output logic        data_in_valid,
  input  logic        decompressor_busy,
  output logic        stream_done,
  output logic        format_error
);
  localparam int CNT_W = $clog2(CONTROL_BITS + 1);

  typedef enum logic [2:0] {
    S_CTRL,
    S_FIRST,
    S_SECOND,
    S_EMIT,
    S_DONE,
    S_ERROR
  } state_t;

  state_t                  r_state;
  state_t                  w_nextState;
  logic [CONTROL_BITS-1:0] r_ctrl;
  logic [CNT_W-1:0]        r_cnt;
  logic [7:0]              r_held;
  logic [15:0]             r_data;
  logic                    r_cw;
  logic                    r_itemLast;
  logic                    r_err;
  logic                    w_inputState;
  logic                    w_byteFire;
  logic                    w_itemFire;
  logic                    w_flag;
  logic [15:0]             w_copyWord;

  // Ready is forced low while reset is held so nothing is taken during reset.
  assign w_inputState  = (r_state == S_CTRL) || (r_state == S_FIRST) || (r_state == S_SECOND);
  assign byte_in_ready = w_inputState && !reset;
  assign w_byteFire    = byte_in_valid && byte_in_ready;
  assign data_in_valid = (r_state == S_EMIT);
  assign w_itemFire    = data_in_valid && !decompressor_busy;
  assign stream_done   = (r_state == S_DONE);
  assign format_error  = r_err;
  assign data_in       = r_data;
  assign control_word_in = r_cw;
  assign w_flag        = r_ctrl[CONTROL_BITS-1];
  assign w_copyWord    = {r_held, byte_in};

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_CTRL;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_CTRL: begin
        if (w_byteFire) w_nextState = byte_in_last ? S_DONE : S_FIRST;
      end
      S_FIRST: begin
        if (w_byteFire) begin
          if (!w_flag)           w_nextState = S_EMIT;
          else if (byte_in_last) w_nextState = S_ERROR;
          else                   w_nextState = S_SECOND;
        end
      end
      S_SECOND: begin
        if (w_byteFire) w_nextState = (w_copyWord == 16'h0000) ? S_ERROR : S_EMIT;
      end
      S_EMIT: begin
        if (w_itemFire) begin
          if (r_itemLast)                 w_nextState = S_DONE;
          else if (r_cnt == CNT_W'(1))    w_nextState = S_CTRL;
          else                            w_nextState = S_FIRST;
        end
      end
      S_DONE:  w_nextState = S_CTRL;
      S_ERROR: w_nextState = S_ERROR;
      default: w_nextState = S_CTRL;
    endcase
  end

  // The item's last flag is captured with its final byte so S_EMIT knows where the stream ends.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_ctrl     <= '0;
      r_cnt      <= '0;
      r_held     <= 8'h00;
      r_data     <= 16'h0000;
      r_cw       <= 1'b0;
      r_itemLast <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        S_CTRL: begin
          if (w_byteFire) begin
            r_ctrl <= byte_in[7 -: CONTROL_BITS];
            r_cnt  <= CNT_W'(CONTROL_BITS);
          end
        end
        S_FIRST: begin
          if (w_byteFire) begin
            if (!w_flag) begin
              r_data     <= {8'h00, byte_in};
              r_cw       <= 1'b0;
              r_itemLast <= byte_in_last;
            end else if (byte_in_last) begin
              r_err <= 1'b1;
            end else begin
              r_held <= byte_in;
            end
          end
        end
        S_SECOND: begin
          if (w_byteFire) begin
            r_data     <= w_copyWord;
            r_cw       <= 1'b1;
            r_itemLast <= byte_in_last;
            if (w_copyWord == 16'h0000) r_err <= 1'b1;
          end
        end
        S_EMIT: begin
          if (w_itemFire) begin
            r_ctrl <= r_ctrl << 1;
            r_cnt  <= r_cnt - CNT_W'(1);
          end
        end
        S_DONE: begin
          r_ctrl <= '0;
          r_cnt  <= '0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decompressor_stream_parser.sv
// Bench for decompressor_stream_parser: random streams checked against a byte-queue
// parsing model, plus directed stall, format-error and mid-stream reset cases.
`timescale 1ns/1ps
module tb_decompressor_stream_parser;
  localparam int CB = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  byte_in;
  logic        byte_in_valid;
  logic        byte_in_last;
  logic        byte_in_ready;
  logic [15:0] data_in;
  logic        control_word_in;
  logic        data_in_valid;
  logic        decompressor_busy;
  logic        stream_done;
  logic        format_error;

  decompressor_stream_parser #(.CONTROL_BITS(CB)) dut (
    .clock             (clock),
    .reset             (reset),
    .byte_in           (byte_in),
    .byte_in_valid     (byte_in_valid),
    .byte_in_last      (byte_in_last),
    .byte_in_ready     (byte_in_ready),
    .data_in           (data_in),
    .control_word_in   (control_word_in),
    .data_in_valid     (data_in_valid),
    .decompressor_busy (decompressor_busy),
    .stream_done       (stream_done),
    .format_error      (format_error)
  );

  always #5 clock = ~clock;

  typedef struct { logic [7:0] b; logic last; } stimByte_t;
  typedef struct { logic [15:0] data; logic cw; logic last; } item_t;

  stimByte_t stim[$];
  item_t     expQ[$];
  item_t     monItem;
  int        checks = 0;
  int        failures = 0;
  int        expDone = 0;
  int        doneSeen = 0;
  logic      expErr = 1'b0;
  bit        monitorOn = 1'b0;
  bit        busyManual = 1'b0;
  int        busyPct = 0;
  bit        sendAbort = 1'b0;
  bit        prevValid, prevBusy, prevFire, prevCw, expDoneNext, nextDone;
  logic [15:0] prevData;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Reference parser: walks the byte queue by the LZRW1 rules and lists the items it must produce.
  task automatic modelStream();
    int          i;
    bit          halt;
    logic [7:0]  ctrl;
    logic [15:0] w;
    item_t       it;
    i = 0;
    halt = 1'b0;
    while (i < stim.size() && !halt) begin
      ctrl = stim[i].b;
      halt = stim[i].last;
      if (halt) expDone++;
      i++;
      for (int k = 0; k < CB && !halt && i < stim.size(); k++) begin
        if (ctrl[7-k] == 1'b0) begin
          it.data = {8'h00, stim[i].b};
          it.cw   = 1'b0;
          it.last = stim[i].last;
          expQ.push_back(it);
          i++;
          if (it.last) begin expDone++; halt = 1'b1; end
        end else if (stim[i].last) begin
          expErr = 1'b1;
          halt = 1'b1;
        end else if (i + 1 >= stim.size()) begin
          halt = 1'b1;
        end else begin
          w = {stim[i].b, stim[i+1].b};
          if (w == 16'h0000) begin
            expErr = 1'b1;
            halt = 1'b1;
          end else begin
            it.data = w;
            it.cw   = 1'b1;
            it.last = stim[i+1].last;
            expQ.push_back(it);
            if (it.last) begin expDone++; halt = 1'b1; end
          end
          i += 2;
        end
      end
    end
  endtask

  task automatic pushStim(input logic [7:0] b, input logic last);
    stimByte_t s;
    s.b = b;
    s.last = last;
    stim.push_back(s);
  endtask

  task automatic genStream(input int nItems);
    int         made, grp;
    logic [7:0] ctrl, b1, b2;
    stim.delete();
    made = 0;
    while (made < nItems) begin
      grp  = (nItems - made < CB) ? nItems - made : CB;
      ctrl = 8'($urandom);
      pushStim(ctrl, 1'b0);
      for (int k = 0; k < grp; k++) begin
        if (ctrl[7-k]) begin
          b1 = 8'($urandom);
          b2 = 8'($urandom);
          if ({b1, b2} == 16'h0000) b2 = 8'h01;
          pushStim(b1, 1'b0);
          pushStim(b2, 1'b0);
        end else begin
          pushStim(8'($urandom), 1'b0);
        end
      end
      made += grp;
    end
    stim[stim.size()-1].last = 1'b1;
  endtask

  task automatic sendByte(input logic [7:0] b, input logic last);
    int waited;
    waited = 0;
    byte_in = b;
    byte_in_last = last;
    byte_in_valid = 1'b1;
    @(negedge clock);
    while (!byte_in_ready && waited < 200) begin
      waited++;
      @(negedge clock);
    end
    checkOutput("byteAccepted", byte_in_ready, 1);
    if (!byte_in_ready) sendAbort = 1'b1;
    @(posedge clock); #1;
    byte_in_valid = 1'b0;
    byte_in = 8'($urandom);
    byte_in_last = 1'($urandom);
    repeat ($urandom_range(2)) begin @(posedge clock); #1; end
  endtask

  task automatic applyStimulus();
    sendAbort = 1'b0;
    foreach (stim[j]) begin
      if (!sendAbort) sendByte(stim[j].b, stim[j].last);
    end
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while (expQ.size() != 0 && n < 2000) begin
      @(negedge clock);
      n++;
    end
    checkOutput("drainTimeout", expQ.size(), 0);
    repeat (3) @(posedge clock);
    #1;
  endtask

  task automatic endChecks();
    checkOutput("doneCount", doneSeen, expDone);
    checkOutput("formatError", format_error, expErr);
  endtask

  task automatic applyReset();
    byte_in_valid = 1'b0;
    reset = 1'b1;
    monitorOn = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    checkOutput("rstReady", byte_in_ready, 0);
    checkOutput("rstData", data_in, 0);
    checkOutput("rstCw", control_word_in, 0);
    checkOutput("rstValid", data_in_valid, 0);
    checkOutput("rstDone", stream_done, 0);
    checkOutput("rstErr", format_error, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    expQ.delete();
    expDone = 0;
    doneSeen = 0;
    expErr = 1'b0;
    monitorOn = 1'b1;
  endtask

  task automatic waitValid();
    int n;
    n = 0;
    @(negedge clock);
    while (!data_in_valid && n < 100) begin
      n++;
      @(negedge clock);
    end
    checkOutput("waitValid", data_in_valid, 1);
  endtask

  task automatic pickBusy();
    case ($urandom_range(2))
      0: busyPct = 0;
      1: busyPct = 25;
      default: busyPct = 60;
    endcase
  endtask

  task automatic randomStream(input int nItems);
    genStream(nItems);
    modelStream();
    applyStimulus();
    waitDrain();
    endChecks();
  endtask

  initial begin
    decompressor_busy = 1'b0;
    forever begin
      @(posedge clock); #1;
      if (!busyManual) decompressor_busy = (int'($urandom_range(99)) < busyPct);
    end
  end

  // Compare process: every item the decompressor takes must be the next one the model predicted.
  initial begin
    forever begin
      @(negedge clock);
      if (!monitorOn) begin
        prevValid = 0; prevBusy = 0; prevFire = 0; prevCw = 0;
        prevData = 16'h0; expDoneNext = 0;
      end else begin
        nextDone = 1'b0;
        if (data_in_valid) begin
          checkOutput("readyLowInEmit", byte_in_ready, 0);
          if (!prevValid) checkOutput("itemLatency", prevFire, 1);
          if (prevValid && prevBusy) begin
            checkOutput("holdData", data_in, prevData);
            checkOutput("holdCw", control_word_in, prevCw);
          end
          if (!decompressor_busy) begin
            if (expQ.size() == 0) begin
              checkOutput("unexpectedItem", data_in_valid, 0);
            end else begin
              monItem = expQ.pop_front();
              checkOutput("itemData", data_in, monItem.data);
              checkOutput("itemCw", control_word_in, monItem.cw);
              nextDone = monItem.last;
            end
          end
        end else if (prevValid && prevBusy) begin
          checkOutput("itemDropped", data_in_valid, 1);
        end
        if (expDoneNext) checkOutput("streamDonePulse", stream_done, 1);
        if (stream_done) doneSeen++;
        expDoneNext = nextDone;
        prevValid = data_in_valid;
        prevBusy  = decompressor_busy;
        prevFire  = byte_in_valid && byte_in_ready;
        prevData  = data_in;
        prevCw    = control_word_in;
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    byte_in = 8'h00;
    byte_in_valid = 1'b0;
    byte_in_last = 1'b0;
    applyReset();

    $display("[TB] all-literal stream");
    busyPct = 0;
    stim.delete();
    pushStim(8'h00, 1'b0);
    for (int k = 0; k < 8; k++) pushStim(8'h41 + 8'(k), k == 7);
    modelStream();
    checkOutput("modelLitCount", expQ.size(), 8);
    checkOutput("modelLitFirst", expQ[0].data, 16'h0041);
    checkOutput("modelLitLastData", expQ[7].data, 16'h0048);
    checkOutput("modelLitLastFlag", expQ[7].last, 1);
    applyStimulus();
    waitDrain();
    endChecks();
    checkOutput("litDoneOnce", doneSeen, 1);

    $display("[TB] mixed group");
    busyPct = 30;
    stim.delete();
    pushStim(8'hA0, 0); pushStim(8'h0C, 0); pushStim(8'h22, 0); pushStim(8'h61, 0);
    pushStim(8'h38, 0); pushStim(8'h4E, 0); pushStim(8'h62, 0); pushStim(8'h63, 0);
    pushStim(8'h64, 0); pushStim(8'h65, 0); pushStim(8'h66, 1);
    modelStream();
    checkOutput("modelMixCount", expQ.size(), 8);
    checkOutput("modelMix0", {expQ[0].cw, expQ[0].data}, {1'b1, 16'h0C22});
    checkOutput("modelMix1", {expQ[1].cw, expQ[1].data}, {1'b0, 16'h0061});
    checkOutput("modelMix2", {expQ[2].cw, expQ[2].data}, {1'b1, 16'h384E});
    applyStimulus();
    waitDrain();
    endChecks();

    $display("[TB] busy stall");
    busyManual = 1'b1;
    decompressor_busy = 1'b1;
    stim.delete();
    pushStim(8'h00, 0);
    pushStim(8'h41, 1);
    modelStream();
    applyStimulus();
    waitValid();
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      checkOutput("stallData", data_in, 16'h0041);
      checkOutput("stallReady", byte_in_ready, 0);
      checkOutput("stallValid", data_in_valid, 1);
    end
    @(posedge clock); #1;
    decompressor_busy = 1'b0;
    @(negedge clock);
    @(negedge clock);
    checkOutput("stallAccepted", data_in_valid, 0);
    checkOutput("stallDone", stream_done, 1);
    busyManual = 1'b0;
    busyPct = 0;
    @(posedge clock); #1;
    waitDrain();
    endChecks();

    $display("[TB] zero-item stream");
    stim.delete();
    pushStim(8'h55, 1);
    modelStream();
    applyStimulus();
    waitDrain();
    endChecks();

    $display("[TB] twenty items over three groups");
    busyPct = 25;
    randomStream(20);

    $display("[TB] random streams");
    for (int t = 0; t < 25; t++) begin
      pickBusy();
      randomStream(int'($urandom_range(1, 20)));
    end

    $display("[TB] truncated copy");
    applyReset();
    busyPct = 0;
    stim.delete();
    pushStim(8'h80, 0);
    pushStim(8'h12, 1);
    modelStream();
    applyStimulus();
    waitDrain();
    endChecks();
    byte_in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      checkOutput("errReady", byte_in_ready, 0);
      checkOutput("errValid", data_in_valid, 0);
      checkOutput("errSticky", format_error, 1);
    end
    @(posedge clock); #1;
    byte_in_valid = 1'b0;
    applyReset();
    randomStream(10);

    $display("[TB] zero copy word");
    stim.delete();
    pushStim(8'h80, 0);
    pushStim(8'h00, 0);
    pushStim(8'h00, 0);
    modelStream();
    applyStimulus();
    waitDrain();
    endChecks();
    applyReset();

    $display("[TB] reset mid-copy");
    busyPct = 30;
    stim.delete();
    pushStim(8'h80, 0);
    pushStim(8'h12, 0);
    applyStimulus();
    applyReset();
    repeat (5) @(posedge clock);
    #1;
    randomStream(20);

    $display("[TB] reset with item pending");
    busyManual = 1'b1;
    decompressor_busy = 1'b1;
    stim.delete();
    pushStim(8'h00, 0);
    pushStim(8'h5A, 0);
    applyStimulus();
    waitValid();
    @(posedge clock); #1;
    applyReset();
    busyManual = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    randomStream(12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
